// File: rtl/fix_session_timer.sv
// FIX session timing: connect requests, heartbeat/test-request/timeout pulses and
// end-of-window logout. Optional FIX_SESSION_STATS_EN adds heartbeat/timeout counters.
module fix_session_timer #(
  parameter int unsigned CNT_W       = 9,
  parameter int unsigned MIN_PER_DAY = 1440
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid_i,
  input  logic [7:0]  heartBeatInt_i,
  input  logic [7:0]  reconnectInt_i,
  input  logic [15:0] starttime_i,
  input  logic [15:0] endtime_i,
  input  logic [15:0] time_now_i,
  input  logic        tick_sec_i,
  input  logic        connected_i,
  input  logic        msg_tx_i,
  input  logic        msg_rx_i,
  output logic        connect_req_o,
  output logic        send_heartbeat_o,
  output logic        send_testreq_o,
  output logic        session_timeout_o,
  output logic        logout_req_o,
  output logic [2:0]  state_o
`ifdef FIX_SESSION_STATS_EN
  ,
  output logic [15:0] hb_sent_cnt_o,
  output logic [15:0] timeout_cnt_o
`endif
);

  localparam int unsigned TW  = 16;
  localparam int unsigned IW  = 8;
  localparam int unsigned SW  = 3;
  localparam int unsigned STW = 16;

  typedef enum logic [SW-1:0] {
    S_IDLE       = 3'd0,
    S_CONNECT    = 3'd1,
    S_ACTIVE     = 3'd2,
    S_TEST_PEND  = 3'd3,
    S_LOGOUT     = 3'd4,
    S_RECON_WAIT = 3'd5
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_e            state_q, state_d;
  logic [IW-1:0]     hb_int_q, recon_int_q;
  logic [TW-1:0]     start_q, end_q;
  logic              configured_q;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]  rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  rc_cnt_q, rc_cnt_d;
  logic              connect_req_q, connect_req_d;
  logic              hb_q, hb_d;
  logic              tr_q, tr_d;
  logic              to_q, to_d;
  logic              lo_q, lo_d;

  logic              in_window;
  logic              in_sess;
  logic              link_ok;
  logic              run_ok;
  logic              hb_en;
  logic [CNT_W-1:0]  hb_cmp;
  logic              hb_due;
  logic              hb_fire;
  logic              tr_fire;
  logic              to_fire;
  logic              lo_fire;
  logic              recon_done;

  // Shadow copy of the session configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_int_q     <= '0;
      recon_int_q  <= '0;
      start_q      <= '0;
      end_q        <= '0;
      configured_q <= 1'b0;
    end else if (cfg_valid_i) begin
      hb_int_q     <= heartBeatInt_i;
      recon_int_q  <= reconnectInt_i;
      start_q      <= starttime_i;
      end_q        <= endtime_i;
      configured_q <= 1'b1;
    end
  end

  // Session window; an out-of-range minute-of-day is never in window
  always_comb begin
    in_window = 1'b0;
    if (time_now_i < TW'(MIN_PER_DAY)) begin
      if (start_q == end_q)
        in_window = 1'b1;
      else if (start_q < end_q)
        in_window = (time_now_i >= start_q) && (time_now_i < end_q);
      else
        in_window = (time_now_i >= start_q) || (time_now_i < end_q);
    end
  end

  // Timer event decode, already qualified by link-down / window-close priority
  always_comb begin
    in_sess    = (state_q == S_ACTIVE) || (state_q == S_TEST_PEND);
    link_ok    = in_sess && connected_i;
    run_ok     = link_ok && in_window;
    hb_en      = (hb_int_q != '0);
    hb_cmp     = CNT_W'(hb_int_q);
    hb_due     = run_ok && hb_en && (tx_cnt_q == hb_cmp);
    hb_fire    = hb_due && !msg_tx_i;
    tr_fire    = run_ok && (state_q == S_ACTIVE) && hb_en &&
                 (rx_cnt_q == hb_cmp + CNT_W'(1));
    to_fire    = run_ok && (state_q == S_TEST_PEND) && hb_en && !msg_rx_i &&
                 (rx_cnt_q == hb_cmp);
    lo_fire    = link_ok && !in_window;
    recon_done = (rc_cnt_q == CNT_W'(recon_int_q));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (configured_q && in_window) state_d = S_CONNECT;
      end
      S_CONNECT: begin
        if (connected_i)     state_d = S_ACTIVE;
        else if (!in_window) state_d = S_IDLE;
      end
      S_ACTIVE: begin
        if (!connected_i)  state_d = S_RECON_WAIT;
        else if (lo_fire)  state_d = S_LOGOUT;
        else if (tr_fire)  state_d = S_TEST_PEND;
      end
      S_TEST_PEND: begin
        if (!connected_i)  state_d = S_RECON_WAIT;
        else if (lo_fire)  state_d = S_LOGOUT;
        else if (msg_rx_i) state_d = S_ACTIVE;
        else if (to_fire)  state_d = S_RECON_WAIT;
      end
      S_LOGOUT: begin
        if (!connected_i) state_d = S_IDLE;
      end
      S_RECON_WAIT: begin
        if (recon_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; connect request tracks the state it is registered with
  always_comb begin
    connect_req_d = (state_d == S_CONNECT);
    hb_d          = hb_fire;
    tr_d          = tr_fire;
    to_d          = to_fire;
    lo_d          = lo_fire;
  end

  // Per-second counters; any clear takes precedence over a tick
  always_comb begin
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    rc_cnt_d = rc_cnt_q;
    if ((state_q == S_CONNECT) && connected_i) begin
      tx_cnt_d = '0;
      rx_cnt_d = '0;
    end else if (in_sess) begin
      if (msg_tx_i || hb_due)   tx_cnt_d = '0;
      else if (tick_sec_i)      tx_cnt_d = sat_inc(tx_cnt_q);
      if (msg_rx_i || tr_fire)  rx_cnt_d = '0;
      else if (tick_sec_i)      rx_cnt_d = sat_inc(rx_cnt_q);
    end
    if ((state_d == S_RECON_WAIT) && (state_q != S_RECON_WAIT))
      rc_cnt_d = '0;
    else if ((state_q == S_RECON_WAIT) && tick_sec_i && !recon_done)
      rc_cnt_d = sat_inc(rc_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt_q      <= '0;
      rx_cnt_q      <= '0;
      rc_cnt_q      <= '0;
      connect_req_q <= 1'b0;
      hb_q          <= 1'b0;
      tr_q          <= 1'b0;
      to_q          <= 1'b0;
      lo_q          <= 1'b0;
    end else begin
      tx_cnt_q      <= tx_cnt_d;
      rx_cnt_q      <= rx_cnt_d;
      rc_cnt_q      <= rc_cnt_d;
      connect_req_q <= connect_req_d;
      hb_q          <= hb_d;
      tr_q          <= tr_d;
      to_q          <= to_d;
      lo_q          <= lo_d;
    end
  end

  assign connect_req_o     = connect_req_q;
  assign send_heartbeat_o  = hb_q;
  assign send_testreq_o    = tr_q;
  assign session_timeout_o = to_q;
  assign logout_req_o      = lo_q;
  assign state_o           = state_q;

`ifdef FIX_SESSION_STATS_EN
  logic [STW-1:0] hb_sent_q, timeouts_q;

  // Event statistics, free-running and wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hb_sent_q  <= '0;
      timeouts_q <= '0;
    end else begin
      if (hb_fire) hb_sent_q  <= hb_sent_q + STW'(1);
      if (to_fire) timeouts_q <= timeouts_q + STW'(1);
    end
  end

  assign hb_sent_cnt_o = hb_sent_q;
  assign timeout_cnt_o = timeouts_q;
`endif

endmodule
